// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between video fetch (fixed priority) and the CPU, with a starvation guard.
// Grants are combinational, memory issue is one cycle later, and read data returns 1+MEM_LATENCY cycles after the grant.
module vram_arbiter #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_vid_req,
  input  logic [ADDR_WIDTH-1:0] i_vid_addr,
  output logic                  o_vid_gnt,
  output logic                  o_vid_rvalid,
  output logic [DATA_WIDTH-1:0] o_vid_rdata,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_cpu_gnt,
  output logic                  o_cpu_rvalid,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic                   w_vid_gnt;
  logic                   w_cpu_gnt;
  logic                   w_cpu_starved;
  logic [3:0]             r_wait_cnt;

  logic                   r_mem_en;
  logic                   r_mem_we;
  logic                   r_mem_cpu;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [DATA_WIDTH-1:0]  r_mem_wdata;

  logic [MEM_LATENCY-1:0] r_tag_vld;
  logic [MEM_LATENCY-1:0] r_tag_cpu;
  logic                   w_tag_in_vld;
  logic                   w_vid_rvalid;
  logic                   w_cpu_rvalid;
  logic [DATA_WIDTH-1:0]  r_vid_rdata;
  logic [DATA_WIDTH-1:0]  r_cpu_rdata;

  assign w_cpu_starved = i_cpu_req && (r_wait_cnt == LP_MAX_WAIT);

  always_comb begin
    w_vid_gnt = 1'b0;
    w_cpu_gnt = 1'b0;
    if (!i_rst) begin
      if (w_cpu_starved) begin
        w_cpu_gnt = 1'b1;
      end else if (i_vid_req) begin
        w_vid_gnt = 1'b1;
      end else if (i_cpu_req) begin
        w_cpu_gnt = 1'b1;
      end
    end
  end

  // Counts consecutive cycles the CPU has been left waiting; saturates so the guard keeps firing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= 4'd0;
    end else if (!i_cpu_req || w_cpu_gnt) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt != LP_MAX_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_cpu   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_vid_gnt | w_cpu_gnt;
      r_mem_we <= w_cpu_gnt & i_cpu_we;
      if (w_vid_gnt) begin
        r_mem_cpu   <= 1'b0;
        r_mem_addr  <= i_vid_addr;
        r_mem_wdata <= '0;
      end else if (w_cpu_gnt) begin
        r_mem_cpu   <= 1'b1;
        r_mem_addr  <= i_cpu_addr;
        r_mem_wdata <= i_cpu_wdata;
      end
    end
  end

  // Tag enters alongside the issued read, so its last stage lines up with mem_rdata.
  assign w_tag_in_vld = r_mem_en & ~r_mem_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag_vld <= '0;
      r_tag_cpu <= '0;
    end else begin
      r_tag_vld[0] <= w_tag_in_vld;
      r_tag_cpu[0] <= r_mem_cpu;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_cpu[i] <= r_tag_cpu[i-1];
      end
    end
  end

  assign w_vid_rvalid = r_tag_vld[MEM_LATENCY-1] & ~r_tag_cpu[MEM_LATENCY-1];
  assign w_cpu_rvalid = r_tag_vld[MEM_LATENCY-1] &  r_tag_cpu[MEM_LATENCY-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vid_rdata <= '0;
      r_cpu_rdata <= '0;
    end else begin
      if (w_vid_rvalid) r_vid_rdata <= i_mem_rdata;
      if (w_cpu_rvalid) r_cpu_rdata <= i_mem_rdata;
    end
  end

  // During the pulse the live memory word is forwarded; the registers keep it afterwards.
  assign o_vid_rdata  = w_vid_rvalid ? i_mem_rdata : r_vid_rdata;
  assign o_cpu_rdata  = w_cpu_rvalid ? i_mem_rdata : r_cpu_rdata;
  assign o_vid_rvalid = w_vid_rvalid;
  assign o_cpu_rvalid = w_cpu_rvalid;
  assign o_vid_gnt    = w_vid_gnt;
  assign o_cpu_gnt    = w_cpu_gnt;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port video RAM between two requesters: the CPU core (read/write) and the scanline fetch unit (read-only).
- Sits inside the invaders core, in front of the VRAM block RAM, in the system clock domain.
- Video fetch has fixed priority. A starvation guard bounds CPU wait.
- Read data is routed back to its owner through a tag pipeline that matches the fixed memory read latency.

Parameters:
- ADDR_WIDTH, 13, VRAM word address width.
- DATA_WIDTH, 8, data width.
- MEM_LATENCY, 1, cycles from mem_en (read) to mem_rdata valid; legal range 1..4.
- MAX_WAIT, 4, consecutive CPU-stalled cycles after which the CPU wins the next arbitration; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- vid_req  in  1  video fetch read request; held with vid_addr stable until vid_gnt.
- vid_addr  in  ADDR_WIDTH  video read address.
- vid_gnt  out  1  combinational; the handshake completes in the cycle where vid_req && vid_gnt.
- vid_rvalid  out  1  one-cycle pulse, video read data valid.
- vid_rdata  out  DATA_WIDTH  video read data.
- cpu_req  in  1  CPU request; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  combinational grant.
- cpu_rvalid  out  1  one-cycle pulse, CPU read data valid; never pulses for writes.
- cpu_rdata  out  DATA_WIDTH  CPU read data.
- mem_en  out  1  registered memory enable.
- mem_we  out  1  registered memory write enable.
- mem_addr  out  ADDR_WIDTH  registered memory address.
- mem_wdata  out  DATA_WIDTH  registered memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after a read mem_en.

Behaviour:
- Throughput: at most one grant per cycle; one transfer per cycle is sustainable. There is no idle state or FSM beyond the wait counter and the tag pipeline.
- Grant selection (combinational, from the current inputs and the wait counter):
  - If cpu_req && wait_cnt == MAX_WAIT: cpu_gnt=1, vid_gnt=0.
  - Else if vid_req: vid_gnt=1.
  - Else if cpu_req: cpu_gnt=1.
  - vid_gnt and cpu_gnt are never both 1. A grant is never asserted without its req.
- wait_cnt (4 bits):
  - Reset to 0.
  - Cleared when cpu_req is low or cpu_gnt is high.
  - Otherwise increments, saturating at MAX_WAIT.
  - With continuous vid_req, the CPU is granted exactly every MAX_WAIT+1 cycles.
- Memory issue: in the cycle after a handshake, mem_en=1 and mem_we/addr/wdata take the winner's values. Video: mem_we=0, mem_wdata=0. With no handshake, mem_en=0 and mem_we=0; addr/wdata hold their previous values.
- Read return:
  - Each issued read pushes a 2-bit tag (valid, owner) into a MEM_LATENCY-deep shift register.
  - At the tag output, mem_rdata is copied to the owner's rdata and its rvalid is pulsed.
  - Total latency from handshake cycle to rvalid is 1+MEM_LATENCY cycles.
  - rdata registers hold their value between pulses.
- Writes push an invalid tag and produce no rvalid.
- Back-to-back reads by mixed owners return strictly in issue order.
- Reset values (rst high at a rising edge; overrides all other activity):
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - vid_rvalid=0, cpu_rvalid=0, vid_rdata=0, cpu_rdata=0.
  - All tags invalid, wait_cnt=0.
  - vid_gnt and cpu_gnt are forced 0 while rst=1.
- Reset mid-operation: reads in flight are discarded and no rvalid follows for them. Requesters re-present after reset.
- Simultaneous requests with wait_cnt < MAX_WAIT: video wins and wait_cnt increments.

Test Plan:
- Reset, then a single CPU write (addr 0x0400, data 0xA5): cpu_gnt high in the same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x0400, mem_wdata=0xA5; no cpu_rvalid ever follows.
- Memory model preloaded with 0x3C at 0x1234; CPU read of 0x1234 with MEM_LATENCY=1: mem_en at T+1; cpu_rvalid=1 and cpu_rdata=0x3C at T+2; vid_rvalid stays 0.
- vid_req held high continuously plus cpu_req held high, MAX_WAIT=4: grants follow the pattern V,V,V,V,C repeating; every CPU request completes within 5 cycles.
- Alternating issue V(0x0010), C-read(0x0020), V(0x0030), with memory returning data = addr[7:0]: vid_rvalid carries 0x10, then cpu_rvalid carries 0x20, then vid_rvalid carries 0x30, on consecutive-issue timing.
- rst asserted one cycle after a CPU read handshake: no cpu_rvalid appears; all outputs equal their reset values on the next edge; normal service resumes after rst deasserts.
- MEM_LATENCY=3, three back-to-back video reads: three vid_rvalid pulses at handshake+4, +5 and +6, with data in issue order.
